multi_lamp_ctrl: RTL
====================

# multi_lamp_ctrl

Parametrised multi-approach traffic-lamp controller, the successor to the single-signal cyclic lamp. It drives NUM_DIR signal heads and grants green to one approach at a time in round-robin order. Each phase has a programmable duration, green is always followed by yellow and then an all-red clearance, and the controller skips approaches with no demand. A flashing-yellow maintenance mode and a freeze enable are added; the block sits between the intersection sensor/command logic and the lamp drivers.

## Interface
- NUM_DIR, 2, number of approaches (≥2)
- GREEN_TICKS, 8, enabled cycles per green phase (≥1)
- YELLOW_TICKS, 3, enabled cycles per yellow phase (≥1)
- ALLRED_TICKS, 2, enabled cycles per all-red clearance (≥1)
- FLASH_TICKS, 4, enabled cycles per flash half-period (≥1)
- CNT_W, 8, phase counter width; every *_TICKS ≤ 2^CNT_W
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  high: timers advance and transitions occur; low: everything holds
- flash_mode  in  1  request flashing-yellow maintenance mode (level)
- req  in  NUM_DIR  per-approach demand, level-sampled
- light  out  3*NUM_DIR  head d at bits [3d+2:3d], encoded RED=100, GREEN=010, YELLOW=001, dark=000
- active_dir  out  clog2(NUM_DIR)  approach currently or most recently served
- phase  out  2  0=ALLRED, 1=GREEN, 2=YELLOW, 3=FLASH
- phase_start  out  1  one-cycle pulse on the first cycle of each new phase

## Operation
- Registered state: phase, active_dir, counter cnt, and flash_on. light is decoded only from these registers, so it changes on the same edge as phase.
- Reset values: phase=ALLRED, cnt=ALLRED_TICKS-1, active_dir=NUM_DIR-1, flash_on=0, phase_start=0, light=all heads 100.
- light decode:
  - ALLRED: all heads are 100.
  - GREEN: head active_dir is 010; all others are 100.
  - YELLOW: head active_dir is 001; all others are 100.
  - FLASH: all heads are 001 when flash_on=1, and 000 otherwise.
- Counter: on phase entry, cnt loads TICKS-1 for the new phase. Each enabled cycle with cnt≠0 decrements it. An enabled cycle with cnt=0 triggers the phase exit.
- Transitions, evaluated only when enable=1:
  - ALLRED, cnt=0, flash_mode=0 → GREEN. active_dir becomes the first d with req[d]=1, searching circularly from active_dir+1 up to and including active_dir. If req is all zero, active_dir becomes (active_dir+1) mod NUM_DIR.
  - ALLRED with flash_mode=1 → FLASH immediately, regardless of cnt.
  - GREEN, cnt=0 → YELLOW.
  - GREEN with flash_mode=1 → YELLOW immediately, truncating green.
  - YELLOW, cnt=0 → FLASH if flash_mode=1, else ALLRED. Yellow is never truncated.
  - FLASH with flash_mode=0 → ALLRED with a full ALLRED_TICKS clearance.
  - FLASH, cnt=0, flash_mode=1 → flash_on toggles and cnt reloads FLASH_TICKS-1.
  - On entry to FLASH, flash_on=1.
- enable=0 holds phase, cnt, active_dir and flash_on. light holds, and phase_start is 0.
- Simultaneous events: flash_mode takes priority over timer expiry in ALLRED and GREEN. In YELLOW, flash_mode only selects the exit target.
- active_dir arithmetic is modulo NUM_DIR; the wrap from NUM_DIR-1 to 0 is required.
- Safety invariant: at most one head shows non-red outside FLASH. GREEN is always followed by YELLOW, and YELLOW by ALLRED or FLASH.

## Timing
- The first enabled edge after reset release counts as ALLRED cycle 1. The first green appears after exactly ALLRED_TICKS enabled cycles.
- Phase lengths, in enabled cycles: green = GREEN_TICKS, yellow = YELLOW_TICKS, all-red = ALLRED_TICKS, each flash half-period = FLASH_TICKS.
- With all req high and enable=1, the steady-state period is NUM_DIR*(GREEN_TICKS+YELLOW_TICKS+ALLRED_TICKS) cycles.
- flash_mode takes effect at the first enabled edge it is sampled high. It costs a one-cycle latency from GREEN to YELLOW.
- phase_start is high for exactly the cycle in which the new phase value first appears, and only in that cycle.
- Reset asserted mid-phase (for example during GREEN): light goes to all-red asynchronously, without waiting for a clock edge.

## Test plan
- Basic cycling: NUM_DIR=2, G=4, Y=2, AR=1, req=11, enable=1, release reset. Expect AR×1, dir0 G×4, Y×2, AR×1, dir1 G×4, Y×2, AR×1, dir0 G. Period is 14 cycles.
- Demand skip: NUM_DIR=4, req=0100 constant. Every GREEN must have active_dir=2. With req=0000, expect the order 0,1,2,3,0, including the wrap.
- Flash entry from GREEN: assert flash_mode at green cycle 2. Expect YELLOW on the next edge for the full Y=2 cycles, then FLASH with light alternating all-001 and all-000 every FLASH_TICKS cycles. Deassert flash_mode: expect ALLRED for AR cycles, then GREEN.
- Enable freeze: drop enable for 5 cycles mid-GREEN. light, phase and cnt must hold, and phase_start stays 0. Green must total exactly GREEN_TICKS enabled cycles.
- Async reset: assert reset between edges during YELLOW. light must read all-100 before the next edge, with phase=0 and active_dir=NUM_DIR-1.
- Invariant checker, run throughout random req/enable/flash_mode stimulus: outside FLASH, at most one head is non-red; no GREEN-to-ALLRED or GREEN-to-FLASH edge ever occurs.

Source files
------------

// File: rtl/multi_lamp_ctrl.sv
// rtl/multi_lamp_ctrl.sv - round-robin multi-approach traffic lamp controller
//
// Purpose: grants green to one approach at a time in circular demand order,
// with green -> yellow -> all-red sequencing, programmable phase lengths,
// a flashing-yellow maintenance mode and a global freeze (enable low).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       1: timers advance and transitions occur, 0: hold
//   flash_mode_i   request flashing-yellow maintenance mode (level)
//   req_i          per-approach demand, level-sampled
//   light_o        head d at [3d+2:3d]: RED=100 GREEN=010 YELLOW=001 dark=000
//   active_dir_o   approach currently or most recently served
//   phase_o        0=ALLRED 1=GREEN 2=YELLOW 3=FLASH
//   phase_start_o  one-cycle pulse on the first cycle of each new phase
module multi_lamp_ctrl #(
  parameter int NUM_DIR      = 2,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int FLASH_TICKS  = 4,
  parameter int CNT_W        = 8,
  localparam int DIR_W       = $clog2(NUM_DIR)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 flash_mode_i,
  input  logic [NUM_DIR-1:0]   req_i,
  output logic [3*NUM_DIR-1:0] light_o,
  output logic [DIR_W-1:0]     active_dir_o,
  output logic [1:0]           phase_o,
  output logic                 phase_start_o
);

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_TICKS - 1);

  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIR_W-1:0]  dir_q, dir_d;
  logic              flash_on_q, flash_on_d;
  logic              phase_start_q, phase_start_d;
  logic [DIR_W-1:0]  next_dir;
  logic [DIR_W:0]    sum;

  // Next approach: first requesting one searching circularly from dir_q+1 up
  // to dir_q itself. Scanning from the far end lets the nearest hit win.
  // With no demand at all, plain round-robin advance.
  always_comb begin
    sum = {1'b0, dir_q} + (DIR_W+1)'(1);
    if (sum >= (DIR_W+1)'(NUM_DIR)) sum = sum - (DIR_W+1)'(NUM_DIR);
    next_dir = sum[DIR_W-1:0];
    for (int i = NUM_DIR; i >= 1; i--) begin
      sum = {1'b0, dir_q} + (DIR_W+1)'(i);
      if (sum >= (DIR_W+1)'(NUM_DIR)) sum = sum - (DIR_W+1)'(NUM_DIR);
      if (req_i[sum[DIR_W-1:0]]) next_dir = sum[DIR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q       <= PH_ALLRED;
      cnt_q         <= ALLRED_LOAD;
      dir_q         <= DIR_W'(NUM_DIR - 1);
      flash_on_q    <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      flash_on_q    <= flash_on_d;
      phase_start_q <= phase_start_d;
    end
  end

  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    flash_on_d    = flash_on_q;
    phase_start_d = 1'b0;
    if (enable_i) begin
      unique case (phase_q)
        PH_ALLRED: begin
          // Maintenance request beats timer expiry.
          if (flash_mode_i) begin
            phase_d       = PH_FLASH;
            cnt_d         = FLASH_LOAD;
            flash_on_d    = 1'b1;
            phase_start_d = 1'b1;
          end else if (cnt_q == '0) begin
            phase_d       = PH_GREEN;
            cnt_d         = GREEN_LOAD;
            dir_d         = next_dir;
            phase_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PH_GREEN: begin
          // Flash request truncates green but never skips yellow.
          if (flash_mode_i || cnt_q == '0) begin
            phase_d       = PH_YELLOW;
            cnt_d         = YELLOW_LOAD;
            phase_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (cnt_q == '0) begin
            phase_start_d = 1'b1;
            if (flash_mode_i) begin
              phase_d    = PH_FLASH;
              cnt_d      = FLASH_LOAD;
              flash_on_d = 1'b1;
            end else begin
              phase_d = PH_ALLRED;
              cnt_d   = ALLRED_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PH_FLASH: begin
          if (!flash_mode_i) begin
            phase_d       = PH_ALLRED;
            cnt_d         = ALLRED_LOAD;
            phase_start_d = 1'b1;
          end else if (cnt_q == '0) begin
            // Half-period toggle stays inside FLASH: not a new phase.
            flash_on_d = ~flash_on_q;
            cnt_d      = FLASH_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          phase_d = PH_ALLRED;
          cnt_d   = ALLRED_LOAD;
        end
      endcase
    end
  end

  // Lamps are decoded purely from registers, so reset darkens to all-red
  // without waiting for a clock edge.
  always_comb begin
    light_o = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      unique case (phase_q)
        PH_GREEN:  light_o[3*d +: 3] = (dir_q == DIR_W'(d)) ? 3'b010 : 3'b100;
        PH_YELLOW: light_o[3*d +: 3] = (dir_q == DIR_W'(d)) ? 3'b001 : 3'b100;
        PH_FLASH:  light_o[3*d +: 3] = flash_on_q ? 3'b001 : 3'b000;
        default:   light_o[3*d +: 3] = 3'b100;
      endcase
    end
  end

  assign active_dir_o  = dir_q;
  assign phase_o       = phase_q;
  assign phase_start_o = phase_start_q;

endmodule
